window_generator: RTL

- Producer side of the 3x3 MAC datapath.
- Accepts a raster-order pixel stream, one pixel per handshake.
- Buffers the two previous image rows and emits each fully-valid 3x3 neighbourhood as nine n-bit outputs, ready to feed the MAC's in0..in8 inputs directly.
- No padding: a WxH frame yields (W-2)*(H-2) windows.

---
 rtl/window_generator_pkg.sv | 16 +
 rtl/window_generator_line_buffer.sv | 23 ++
 rtl/window_generator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/window_generator_pkg.sv
// Shared constants for the 3x3 window producer and the MAC that consumes it.
package window_generator_pkg;

  // Default geometry and pixel width.
  localparam int WG_N_DEF = 8;
  localparam int WG_W_DEF = 8;
  localparam int WG_H_DEF = 8;

  // Window taps, row-major: tap k drives kernel slice [(k+1)*n-1 : k*n].
  localparam int WIN_TAPS   = 9;
  localparam int WIN_ROWS   = 3;
  localparam int WIN_TOP_IN = 2;   // tap loaded from the older line buffer
  localparam int WIN_MID_IN = 5;   // tap loaded from the newer line buffer
  localparam int WIN_NEWEST = 8;   // tap loaded from the incoming pixel

endpackage

// File: rtl/window_generator_line_buffer.sv
// One image row of storage: combinational read of the old value at addr,
// write of din at addr on the same edge. Contents are never reset.
module line_buffer #(
  parameter int n = 8,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(W)-1:0] addr,
  input  logic [n-1:0]         din,
  output logic [n-1:0]         dout
);

  logic [n-1:0] mem [W];

  assign dout = mem[addr];

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/window_generator.sv
// Raster-stream to 3x3 neighbourhood generator. Two line buffers hold the
// previous two rows; a 3x3 shift register slides one column per accepted
// pixel. Only windows fully inside the current frame are flagged valid.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int n = WG_N_DEF,
  parameter int W = WG_W_DEF,
  parameter int H = WG_H_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] pix_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] win0,
  output logic [n-1:0] win1,
  output logic [n-1:0] win2,
  output logic [n-1:0] win3,
  output logic [n-1:0] win4,
  output logic [n-1:0] win5,
  output logic [n-1:0] win6,
  output logic [n-1:0] win7,
  output logic [n-1:0] win8,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_last
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          full_win;
  logic [n-1:0]  top;
  logic [n-1:0]  mid;
  logic [n-1:0]  win_q [WIN_TAPS];

  // A held window blocks input; consuming it frees the slot in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  // Columns 0/1 carry wrapped data from the previous row, rows 0/1 carry
  // data from the previous frame; neither may be emitted.
  assign full_win = (row >= RW'(2)) && (col >= CW'(2));

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old value.
  line_buffer #(.n(n), .W(W)) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (pix_in),
    .dout (mid)
  );

  line_buffer #(.n(n), .W(W)) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (mid),
    .dout (top)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // 3x3 window: each row shifts left, new column enters on the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_TAPS; i++) win_q[i] <= '0;
    end else if (accept) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        win_q[3*r]   <= win_q[3*r+1];
        win_q[3*r+1] <= win_q[3*r+2];
      end
      win_q[WIN_TOP_IN] <= top;
      win_q[WIN_MID_IN] <= mid;
      win_q[WIN_NEWEST] <= pix_in;
    end
  end

  // Output qualifiers: load on accept, clear once consumed, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_last <= 1'b0;
    end else if (accept) begin
      out_valid  <= full_win;
      frame_last <= row_end && col_end;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_last <= 1'b0;
    end
  end

  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

endmodule
